// File: rtl/mul_share_sched.sv
// mul_share_sched
//   Round-robin front end for a single sequential radix-2 shift-add signed
//   8x8 multiplier shared by N_REQ requesters. One request is granted at a
//   time. The winner's operands are latched and run through 16 shift-add
//   iterations. The 16-bit product then goes back to the winner over a
//   valid/ready response handshake.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : one-hot grant (combinational, only in IDLE)
//   req_a      : signed multiplicands, requester i in [8i+7:8i]
//   req_b      : signed multipliers,   requester i in [8i+7:8i]
//   rsp_valid  : one-hot product valid towards the owner
//   rsp_ready  : per-requester response ready (only the owner's bit matters)
//   rsp_p      : signed 16-bit product
//   busy       : high whenever the scheduler is not idle
//   owner      : index of the current / last granted requester
module mul_share_sched #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [8*N_REQ-1:0]        req_a,
    input  logic [8*N_REQ-1:0]        req_b,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic signed [15:0]        rsp_p,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
);

    localparam int DATA_W = 8;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [IDX_W-1:0]           rr_ptr;
    logic [3:0]                 ctr;
    logic signed [PROD_W-1:0]   acc;
    logic signed [PROD_W-1:0]   acc_nx;
    logic signed [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]          mplier;
    logic                       rsp_vld_q;

    logic                       found;
    logic [IDX_W-1:0]           grant_idx;
    logic [DATA_W-1:0]          win_a;
    logic [DATA_W-1:0]          win_b;
    logic                       accept;
    logic                       rsp_hs;

    function automatic logic signed [PROD_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(PROD_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        logic [IDX_W-1:0] cand;
        found     = 1'b0;
        grant_idx = '0;
        win_a     = '0;
        win_b     = '0;
        j         = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = IDX_W'(j);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
                win_a     = req_a[8*j +: 8];
                win_b     = req_b[8*j +: 8];
            end
        end
    end

    assign accept = (state_q == IDLE) && found;
    assign rsp_hs = (state_q == DONE) && rsp_vld_q && rsp_ready[owner];
    assign busy   = (state_q != IDLE);

    // Grant is suppressed while reset is asserted so nothing is accepted
    // on the reset edge.
    always_comb begin
        req_ready = '0;
        if (accept && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_vld_q) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    // One radix-2 step: add the shifted multiplicand when the current
    // multiplier bit is set. Sign-extended operands make the 16-bit
    // modulo sum equal to the exact signed product.
    always_comb begin
        acc_nx = mplier[ctr] ? (acc + mcand) : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (ctr == 4'd15) state_d = DONE;
            DONE: if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            ctr       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rsp_p     <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand  <= sext(win_a);
                        mplier <= sext(win_b);
                        owner  <= grant_idx;
                        acc    <= '0;
                        ctr    <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    mcand <= mcand <<< 1;
                    ctr   <= ctr + 4'd1;
                    if (ctr == 4'd15) begin
                        rsp_p <= acc_nx;
                    end
                end
                DONE: begin
                    // Response valid is raised one cycle after entering DONE
                    // and is only retired by the owner's own ready.
                    if (!rsp_vld_q) begin
                        rsp_vld_q <= 1'b1;
                    end else if (rsp_ready[owner]) begin
                        rsp_vld_q <= 1'b0;
                        rr_ptr    <= (owner == IDX_W'(N_REQ-1)) ? '0 : owner + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic [3:0]         rsp_valid;
    logic [3:0]         rsp_ready;
    logic signed [15:0] rsp_p;
    logic               busy;
    logic [1:0]         owner;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mul_share_sched #(.N_REQ(4), .IDX_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Full transaction on requester r with rsp_ready held high. If scramble
    // is set, the requester's operands are changed right after the accept.
    task automatic do_mul(input int r, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit scramble, input string tag);
        int n;
        int bc;
        rsp_ready = 4'b1111;
        req_a[8*r +: 8] = a;
        req_b[8*r +: 8] = b;
        req_valid = 4'b0000;
        req_valid[r] = 1'b1;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(1 << r));
        tick();
        req_valid = 4'b0000;
        if (scramble) begin
            req_a[8*r +: 8] = ~a;
            req_b[8*r +: 8] = b + 8'd1;
        end
        bc = busy ? 1 : 0;
        n = 0;
        while (rsp_valid == 4'b0000 && n < 40) begin
            tick();
            n++;
            bc = bc + (busy ? 1 : 0);
        end
        chk({tag, "_latency"}, 32'(n), 32'd17);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
        chk({tag, "_rsp_p"}, {16'd0, rsp_p}, {16'd0, exp});
        chk({tag, "_owner"}, 32'(owner), 32'(r));
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd18);
        tick();
        chk({tag, "_rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ord[5];
        int n;
        logic signed [15:0] held;
        ord = '{0, 1, 2, 3, 0};

        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 4'b1111;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_p", {16'd0, rsp_p}, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        req_valid = 4'b0000;
        reset = 1'b0;
        tick();

        // Round robin with every requester asking; products a_i=i+1, b=3.
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'd3;
        end
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << ord[t]));
            tick();
            wait_rsp(n);
            chk("rr_latency", 32'(n), 32'd17);
            chk("rr_owner", 32'(owner), 32'(ord[t]));
            chk("rr_rsp_p", {16'd0, rsp_p}, 32'(3 * (ord[t] + 1)));
            tick();
        end
        req_valid = 4'b0000;

        do_mul(0, 8'hFD, 8'h05, 16'hFFF1, 1'b0, "single");
        do_mul(2, 8'h7F, 8'h7F, 16'h3F01, 1'b0, "c_127x127");
        do_mul(2, 8'h80, 8'h80, 16'h4000, 1'b0, "c_m128xm128");
        do_mul(2, 8'h80, 8'h7F, 16'hC080, 1'b0, "c_m128x127");
        do_mul(2, 8'h00, 8'hFF, 16'h0000, 1'b0, "c_0xm1");

        // rr_ptr is now 3: check wrap behaviour of the search.
        req_valid = 4'b1111;
        #1;
        chk("ptr3_all", 32'(req_ready), 32'b1000);
        req_valid = 4'b0011;
        #1;
        chk("ptr3_wrap", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        #1;
        chk("idle_none", 32'(req_ready), 32'd0);
        // Only requester 1 valid; operands scrambled after the accept.
        do_mul(1, 8'h80, 8'hFF, 16'h0080, 1'b1, "ptr3_req1_stable");

        // Backpressure on owner 0 (rr_ptr is 2, only requester 0 asks).
        rsp_ready = 4'b1111;
        req_a[7:0] = 8'h07;
        req_b[7:0] = 8'h09;
        req_valid = 4'b0001;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        rsp_ready = 4'b1110;
        wait_rsp(n);
        chk("bp_latency", 32'(n), 32'd17);
        chk("bp_rsp_p", {16'd0, rsp_p}, 32'h003F);
        held = rsp_p;
        req_valid = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'b0001);
            chk("bp_hold_p", {16'd0, rsp_p}, {16'd0, held});
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 4'b0001;
        tick();
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;

        // Reset in the middle of a run on requester 3.
        req_a[31:24] = 8'h11;
        req_b[31:24] = 8'h22;
        req_valid = 4'b1000;
        #1;
        chk("mr_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        chk("mr_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("mr_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_owner", 32'(owner), 32'd0);
        chk("mr_rsp_p", {16'd0, rsp_p}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mr_ptr0", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
        do_mul(2, 8'h05, 8'h06, 16'h001E, 1'b0, "mr_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
